fpu_op_sequencer: RTL and testbench
===================================

Name: fpu_op_sequencer

Overview:
- Controller that owns the shared combinational F32 add/mul datapath (the FPU block: op1/op2/funct/round_mode in, result out).
- Accepts one command at a time over a valid/ready request channel and decodes it into one or two datapath passes: ADD, SUB, MUL, MADD (op1*op2+op3) and MSUB (op1*op2-op3).
- Returns the result over a valid/ready response channel.
- Sits between the integer pipeline's FP issue stage and the FPU instance; the FPU itself is unchanged.

Parameters:
- CNT_W, 16, width of the completed-operation counter.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- req_valid  in  1  command valid
- req_ready  out  1  sequencer can accept a command
- req_funct  in  5  1=ADD, 2=MUL, 3=MADD, 4=MSUB, 5=SUB, others illegal
- req_op1  in  32  operand 1 (IEEE-754 single)
- req_op2  in  32  operand 2
- req_op3  in  32  addend for MADD/MSUB, ignored otherwise
- req_round_mode  in  2  00 nearest, 01 toward zero, 10 downward, 11 upward
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  32  result
- rsp_err  out  1  illegal funct flag, qualified by rsp_valid
- dp_op1  out  32  datapath operand 1
- dp_op2  out  32  datapath operand 2
- dp_funct  out  5  datapath select: 1=add, 2=mul
- dp_round_mode  out  2  datapath rounding mode
- dp_result  in  32  datapath result, combinational from dp_* outputs
- op_count  out  CNT_W  completed responses since reset, wraps

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous, active-high, and dominates all other inputs.
- State on reset:
  - state=IDLE
  - rsp_valid=0, rsp_result=0, rsp_err=0
  - op_count=0
  - all operand, funct and round-mode registers =0
  - dp_* outputs =0
- Reset mid-operation abandons the command; no response is issued.
- States: IDLE, EXEC1, EXEC2, DONE.
- req_ready = (state==IDLE). It is low in all other states; no command overlap.
- IDLE:
  - Handshake occurs when req_valid && req_ready.
  - On handshake, latch op1/op2/op3/funct/round_mode and go to EXEC1.
- EXEC1, driving the datapath from registers:
  - ADD: dp_op1=op1, dp_op2=op2, dp_funct=1.
  - SUB: dp_op1=op1, dp_op2=op2 with bit31 inverted, dp_funct=1.
  - MUL, MADD, MSUB: dp_op1=op1, dp_op2=op2, dp_funct=2.
  - Illegal funct: dp_* =0.
  - dp_round_mode = latched mode in all cases.
- Leaving EXEC1:
  - ADD, SUB, MUL: capture dp_result into rsp_result, go to DONE.
  - MADD, MSUB: capture dp_result into an internal product register, go to EXEC2.
  - Illegal funct: rsp_result=32'h7FC00000, rsp_err=1, go to DONE.
- EXEC2 (MADD/MSUB only):
  - dp_op1=product, dp_funct=1.
  - dp_op2=op3 for MADD; op3 with bit31 inverted for MSUB.
  - Capture dp_result into rsp_result, go to DONE.
  - The product is rounded once after the multiply pass: this is a non-fused multiply-add. Intended, not a defect.
- DONE:
  - rsp_valid=1; rsp_result and rsp_err are held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: go to IDLE, clear rsp_valid and rsp_err, op_count += 1 (modulo 2^CNT_W; illegal ops count too).
- dp_* outputs are 0 in IDLE and DONE, so the datapath inputs stay quiet.
- Latency, with the handshake in cycle t:
  - single-pass ops and illegal funct: rsp_valid in cycle t+2;
  - MADD/MSUB: rsp_valid in cycle t+3.
- Throughput is at best one op per 3 cycles (single-pass) or 4 cycles (two-pass).
- Changing req_* inputs after acceptance has no effect on the op in flight.

Test Plan:
- ADD: op1=0x3FC00000, op2=0x40100000, mode 00, rsp_ready=1 -> rsp_valid at t+2, rsp_result=0x40700000, rsp_err=0, op_count=1.
- MUL then SUB back-to-back:
  - MUL 0x40000000*0x40400000 -> 0x40C00000.
  - SUB 0x40400000-0x40000000 -> 0x3F800000.
  - req_ready must be low from t+1 until return to IDLE.
- MADD and MSUB:
  - MADD op1=0x40000000, op2=0x40400000, op3=0x3F800000 -> 0x40E00000 at t+3; dp_funct observed as 2 then 1.
  - MSUB with the same operands -> 0x40A00000.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> result stable, req_ready=0, op_count unchanged; rsp_ready=1 -> op_count increments once, IDLE next cycle.
- Illegal funct=7 -> rsp_result=0x7FC00000, rsp_err=1 at t+2; op_count increments on acceptance of the response.
- Reset: assert RST during EXEC2 of a MADD -> next cycle all outputs 0, req_ready=1, no rsp_valid. Also preset op_count to 0xFFFF via 65535 ops (or a forced value) and complete one more -> op_count=0.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: sequences ADD/SUB/MUL/MADD/MSUB commands over a shared F32 add/mul datapath
module fpu_op_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_funct,
    input  logic [31:0]      req_op1,
    input  logic [31:0]      req_op2,
    input  logic [31:0]      req_op3,
    input  logic [1:0]       req_round_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_err,
    output logic [31:0]      dp_op1,
    output logic [31:0]      dp_op2,
    output logic [4:0]       dp_funct,
    output logic [1:0]       dp_round_mode,
    input  logic [31:0]      dp_result,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] op1, op2, op3, prod;
    logic [4:0] funct;
    logic [1:0] rm;
    logic is_add, is_sub, is_mul, is_fma, is_ill;
    assign is_add = funct == 5'd1;
    assign is_sub = funct == 5'd5;
    assign is_mul = funct == 5'd2;
    assign is_fma = funct == 5'd3 || funct == 5'd4;
    assign is_ill = !(is_add || is_sub || is_mul || is_fma);
    assign req_ready = state == IDLE;
    assign rsp_valid = state == DONE;
    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_nx;
    end
    // Next state and datapath drive; datapath inputs stay zero outside execute passes
    always_comb begin
        state_nx = state;
        dp_op1 = '0;
        dp_op2 = '0;
        dp_funct = '0;
        dp_round_mode = '0;
        case (state)
            IDLE: state_nx = req_valid ? EXEC1 : IDLE;
            EXEC1: begin
                state_nx = is_fma ? EXEC2 : DONE;
                if (!is_ill) begin
                    dp_op1 = op1;
                    dp_op2 = is_sub ? {~op2[31], op2[30:0]} : op2;
                    dp_funct = (is_add || is_sub) ? 5'd1 : 5'd2;
                    dp_round_mode = rm;
                end
            end
            EXEC2: begin
                state_nx = DONE;
                dp_op1 = prod;
                dp_op2 = funct == 5'd4 ? {~op3[31], op3[30:0]} : op3;
                dp_funct = 5'd1;
                dp_round_mode = rm;
            end
            DONE: state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // Command latch, product/result capture and completion counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            op1 <= '0;
            op2 <= '0;
            op3 <= '0;
            funct <= '0;
            rm <= '0;
            prod <= '0;
            rsp_result <= '0;
            rsp_err <= 1'b0;
            op_count <= '0;
        end else begin
            if (req_valid && req_ready) begin
                op1 <= req_op1;
                op2 <= req_op2;
                op3 <= req_op3;
                funct <= req_funct;
                rm <= req_round_mode;
            end
            if (state == EXEC1 && is_fma) prod <= dp_result;
            if (state == EXEC1 && !is_fma) begin
                rsp_result <= is_ill ? 32'h7FC0_0000 : dp_result;
                rsp_err <= is_ill;
            end
            if (state == EXEC2) rsp_result <= dp_result;
            if (state == DONE && rsp_ready) begin
                rsp_err <= 1'b0;
                op_count <= op_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: randomized scoreboard bench with a real-arithmetic FPU and command-level model
module tb_fpu_op_sequencer;
    localparam int CNT_W = 4;
    logic CLK = 0, RST = 1, req_valid = 0, rsp_ready = 1;
    logic [4:0] req_funct = 0;
    logic [31:0] req_op1 = 0, req_op2 = 0, req_op3 = 0;
    logic [1:0] req_round_mode = 0;
    logic req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_result, dp_op1, dp_op2, dp_result;
    logic [4:0] dp_funct;
    logic [1:0] dp_round_mode;
    logic [CNT_W-1:0] op_count;

    fpu_op_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct(req_funct), .req_op1(req_op1), .req_op2(req_op2), .req_op3(req_op3),
        .req_round_mode(req_round_mode), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .dp_op1(dp_op1), .dp_op2(dp_op2),
        .dp_funct(dp_funct), .dp_round_mode(dp_round_mode), .dp_result(dp_result),
        .op_count(op_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] f;
        logic [31:0] a, b, c;
        logic [1:0] rm;
        logic [31:0] res;
        logic err;
    } op_t;
    op_t q[$];
    int total = 0, passed = 0, rr_mode = 0, age = 0;
    bit busy = 0, just_rst = 0;
    logic [CNT_W-1:0] exp_cnt = 0;

    function automatic real to_real(input logic [31:0] f);
        if (f[30:23] == 0) return 0.0;
        return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] to_f32(input real x);
        logic [63:0] d = $realtobits(x);
        if (d[62:52] == 0) return {d[63], 31'b0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] ref_res(input logic [4:0] f, input logic [31:0] a, b, c);
        real p = to_real(to_f32(to_real(a) * to_real(b)));
        case (f)
            5'd1: return to_f32(to_real(a) + to_real(b));
            5'd5: return to_f32(to_real(a) - to_real(b));
            5'd2: return to_f32(to_real(a) * to_real(b));
            5'd3: return to_f32(p + to_real(c));
            5'd4: return to_f32(p - to_real(c));
            default: return 32'h7FC0_0000;
        endcase
    endfunction

    function automatic logic [31:0] rnd_f();
        int v = $urandom_range(1, 64);
        int k = $urandom_range(0, 3);
        real r = real'(v) / real'(1 << k);
        if ($urandom_range(0, 1) == 1) r = -r;
        return to_f32(r);
    endfunction

    always_comb begin
        dp_result = 32'h0;
        if (dp_funct == 5'd1) dp_result = to_f32(to_real(dp_op1) + to_real(dp_op2));
        if (dp_funct == 5'd2) dp_result = to_f32(to_real(dp_op1) * to_real(dp_op2));
    end

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    // Monitor: checks handshake, datapath drive and responses against the in-flight command
    always @(negedge CLK) begin : mon
        op_t o;
        logic [31:0] ea, eb;
        logic [4:0] ef;
        logic [1:0] erm;
        bit two, ev;
        if (busy) age++;
        ea = 0; eb = 0; ef = 0; erm = 0; ev = 0; two = 0;
        if (busy && q.size() > 0) begin
            o = q[0];
            two = o.f == 5'd3 || o.f == 5'd4;
            if (age == 1 && o.f inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}) begin
                ea = o.a;
                eb = o.f == 5'd5 ? {~o.b[31], o.b[30:0]} : o.b;
                ef = o.f inside {5'd1, 5'd5} ? 5'd1 : 5'd2;
                erm = o.rm;
            end
            if (age == 2 && two) begin
                ea = to_f32(to_real(o.a) * to_real(o.b));
                eb = o.f == 5'd4 ? {~o.c[31], o.c[30:0]} : o.c;
                ef = 5'd1;
                erm = o.rm;
            end
            ev = age >= (two ? 3 : 2);
        end
        chk("req_ready", req_ready, !busy);
        chk("op_count", op_count, exp_cnt);
        chk("rsp_valid", rsp_valid, ev);
        chk("dp_drive", {dp_op1, dp_op2, dp_funct, dp_round_mode}, {ea, eb, ef, erm});
        if (just_rst) chk("rsp_after_reset", {rsp_result, rsp_err}, 33'h0);
        just_rst = 0;
        if (ev && rsp_valid) chk("rsp_result_err", {rsp_result, rsp_err}, {o.res, o.err});
        if (RST) begin
            busy = 0;
            q.delete();
            exp_cnt = 0;
            just_rst = 1;
        end else begin
            if (ev && rsp_valid && rsp_ready) begin
                void'(q.pop_front());
                busy = 0;
                exp_cnt++;
            end
            if (req_valid && req_ready) begin
                busy = 1;
                age = 0;
            end
        end
    end

    // Response consumer: always ready, random, or stalled
    initial forever begin
        @(posedge CLK);
        #1;
        rsp_ready = rr_mode == 0 ? 1'b1 : rr_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [4:0] f, input logic [31:0] a, b, c, input logic [1:0] rm,
                         input bit gold, input logic [31:0] gres);
        op_t o;
        int n = 0;
        @(posedge CLK);
        #1;
        req_funct = f; req_op1 = a; req_op2 = b; req_op3 = c; req_round_mode = rm;
        req_valid = 1;
        forever begin
            @(negedge CLK);
            if (req_ready) break;
            if (++n > 200) break;
        end
        if (n > 200) begin
            total++;
            $display("FAIL issue_timeout: got req_ready=0 expected 1 within 200 cycles");
        end else begin
            o = '{f, a, b, c, rm, gold ? gres : ref_res(f, a, b, c),
                  !(f inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5})};
            q.push_back(o);
        end
        @(posedge CLK);
        #1;
        req_valid = 0;
        req_funct = 5'($urandom); req_op1 = $urandom; req_op2 = $urandom; req_op3 = $urandom;
        req_round_mode = 2'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge CLK);
            #1;
        end while (busy && ++n < 300);
        if (busy) begin
            total++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within 300 cycles");
        end
    endtask

    initial begin
        int n;
        logic [4:0] f;
        repeat (3) @(posedge CLK);
        #1 RST = 0;
        issue(5'd1, 32'h3FC0_0000, 32'h4010_0000, 32'h0, 2'd0, 1, 32'h4070_0000);
        wait_idle();
        issue(5'd2, 32'h4000_0000, 32'h4040_0000, 32'h0, 2'd1, 1, 32'h40C0_0000);
        issue(5'd5, 32'h4040_0000, 32'h4000_0000, 32'h0, 2'd3, 1, 32'h3F80_0000);
        wait_idle();
        issue(5'd3, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'd2, 1, 32'h40E0_0000);
        issue(5'd4, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'd1, 1, 32'h40A0_0000);
        wait_idle();
        issue(5'd7, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'd3, 1, 32'h7FC0_0000);
        wait_idle();
        rr_mode = 2;
        issue(5'd1, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 2'd0, 1, 32'h4000_0000);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        repeat (5) @(negedge CLK);
        rr_mode = 0;
        wait_idle();
        issue(5'd3, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'd2, 1, 32'h40E0_0000);
        @(posedge CLK);
        #1 RST = 1;
        @(posedge CLK);
        #1 RST = 0;
        repeat (2) @(negedge CLK);
        rr_mode = 1;
        repeat (200) begin
            n = $urandom_range(0, 11);
            f = n < 10 ? 5'(n % 5 + 1) : (n == 10 ? 5'd0 : 5'($urandom_range(6, 31)));
            issue(f, rnd_f(), rnd_f(), rnd_f(), 2'($urandom), 0, 32'h0);
        end
        wait_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
